// File: rtl/stack_arb_pkg.sv
// Shared constants and FSM state type for the recursion-stack arbiter.
package stack_arb_pkg;

    localparam logic [1:0] RW_PUSH = 2'd0;
    localparam logic [1:0] RW_POP  = 2'd1;
    localparam logic [1:0] RW_NOP  = 2'd2;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        ISSUE    = 2'd2,
        POP_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = (int'(i_ptr) + off) % NUM_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Sequences pushes/pops from several requesters onto one reset-less stack,
// tracking occupancy and resynchronising the stack pointer after reset.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic [1:0]                stack_rw,
    output logic [DATA_W-1:0]         stack_push,
    input  logic [DATA_W-1:0]         stack_pop,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_init_cnt, w_init_cnt_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]    r_win, w_win_nxt;
    logic                r_op, w_op_nxt;
    logic                r_err, w_err_nxt;
    logic [1:0]          r_stack_rw, w_stack_rw_nxt;
    logic [DATA_W-1:0]   r_stack_push, w_stack_push_nxt;
    logic [NUM_REQ-1:0]  r_resp_valid, w_resp_valid_nxt;
    logic [DATA_W-1:0]   r_resp_data, w_resp_data_nxt;
    logic                r_resp_err, w_resp_err_nxt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_full;
    logic                w_empty;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_init_cnt_nxt   = r_init_cnt;
        w_count_nxt      = r_count;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_win_nxt        = r_win;
        w_op_nxt         = r_op;
        w_err_nxt        = r_err;
        w_stack_rw_nxt   = r_stack_rw;
        w_stack_push_nxt = r_stack_push;
        w_resp_valid_nxt = '0;
        w_resp_data_nxt  = r_resp_data;
        w_resp_err_nxt   = 1'b0;

        unique case (r_state)
            INIT: begin
                // DEPTH pops walk any stale pointer back to base; extras are ignored
                if (r_init_cnt == DEPTH_C) begin
                    w_stack_rw_nxt = RW_NOP;
                    w_state_nxt    = IDLE;
                end else begin
                    w_stack_rw_nxt = RW_POP;
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (w_any) begin
                    w_win_nxt    = w_idx;
                    w_op_nxt     = req_op[w_idx];
                    w_rr_ptr_nxt = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                    w_state_nxt  = ISSUE;
                    if (req_op[w_idx] == OP_PUSH) begin
                        w_err_nxt = w_full;
                        if (w_full) begin
                            w_stack_rw_nxt = RW_NOP;
                        end else begin
                            w_stack_rw_nxt   = RW_PUSH;
                            w_stack_push_nxt = req_data[int'(w_idx)*DATA_W +: DATA_W];
                        end
                    end else begin
                        w_err_nxt      = w_empty;
                        w_stack_rw_nxt = w_empty ? RW_NOP : RW_POP;
                    end
                end
            end
            ISSUE: begin
                w_stack_rw_nxt = RW_NOP;
                if (r_err) begin
                    w_resp_valid_nxt[r_win] = 1'b1;
                    w_resp_err_nxt          = 1'b1;
                    w_state_nxt             = IDLE;
                end else if (r_op == OP_PUSH) begin
                    w_count_nxt             = r_count + 1'b1;
                    w_resp_valid_nxt[r_win] = 1'b1;
                    w_state_nxt             = IDLE;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                    w_state_nxt = POP_WAIT;
                end
            end
            POP_WAIT: begin
                w_resp_data_nxt         = stack_pop;
                w_resp_valid_nxt[r_win] = 1'b1;
                w_state_nxt             = IDLE;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= INIT;
            r_init_cnt   <= '0;
            r_count      <= '0;
            r_rr_ptr     <= '0;
            r_win        <= '0;
            r_op         <= OP_PUSH;
            r_err        <= 1'b0;
            r_stack_rw   <= RW_NOP;
            r_stack_push <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_cnt   <= w_init_cnt_nxt;
            r_count      <= w_count_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_win        <= w_win_nxt;
            r_op         <= w_op_nxt;
            r_err        <= w_err_nxt;
            r_stack_rw   <= w_stack_rw_nxt;
            r_stack_push <= w_stack_push_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign req_ready  = (r_state == IDLE) ? w_grant : '0;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign stack_rw   = r_stack_rw;
    assign stack_push = r_stack_push;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small reset-less stack model attached.
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_op = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  stack_rw;
    logic [31:0] stack_push;
    logic [31:0] stack_pop;
    logic [1:0]  count;
    logic        full;
    logic        empty;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Stack model: no reset, pointer starts off-base so INIT has real work to do
    logic [31:0] mem [0:7];
    int          sp = 2;
    logic [31:0] pop_q = '0;
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;

    assign stack_pop = force_en ? force_val : pop_q;

    always @(posedge clk) begin
        if (stack_rw == 2'd0 && sp < 8) begin
            mem[sp] <= stack_push;
            sp      <= sp + 1;
        end else if (stack_rw == 2'd1 && sp > 0) begin
            pop_q <= mem[sp-1];
            sp    <= sp - 1;
        end
    end

    always #5 clk = ~clk;

    stack_arbiter #(
        .NUM_REQ (2),
        .DATA_W  (32),
        .DEPTH   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .stack_rw   (stack_rw),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request to completion; reports the response and ISSUE-cycle stack command
    task automatic do_op(input int r, input logic op, input logic [31:0] d,
                         output logic [1:0] rv, output logic [31:0] rd, output logic re,
                         output logic [1:0] rw_i, output int lat);
        int wait_n;
        rv = '0; rd = '0; re = 1'b0; rw_i = 2'd3; lat = -1;
        req_valid[r] = 1'b1;
        req_op[r] = op;
        req_data[r*32 +: 32] = d;
        #1;
        wait_n = 0;
        while (!req_ready[r] && wait_n < 20) begin
            tick();
            wait_n++;
        end
        if (!req_ready[r]) begin
            vectors++; miscompares++;
            $display("FAIL grant_timeout req%0d: no req_ready within 20 cycles", r);
            req_valid[r] = 1'b0;
            return;
        end
        tick();
        req_valid[r] = 1'b0;
        rw_i = stack_rw;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (resp_valid != 0) begin
                rv = resp_valid; rd = resp_data; re = resp_err; lat = i;
                return;
            end
        end
    endtask

    // Expects DEPTH pop cycles then NOP/idle, with no responses leaking out
    task automatic check_init(input string tag);
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (stack_rw !== 2'd1 || busy !== 1'b1 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
                miscompares++;
                $display("FAIL %s_init_pop%0d: rw=%0d busy=%b rv=%b rdy=%b, want rw=1 busy=1 rv=00 rdy=00",
                         tag, i, stack_rw, busy, resp_valid, req_ready);
            end
        end
        tick();
        vectors++;
        if (stack_rw !== 2'd2 || busy !== 1'b0 || count !== 2'd0 || empty !== 1'b1 || resp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_init_done: rw=%0d busy=%b count=%0d empty=%b rv=%b, want 2 0 0 1 00",
                     tag, stack_rw, busy, count, empty, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        vectors++;
        if (stack_rw !== 2'd2 || busy !== 1'b1 || count !== 2'd0 || resp_valid !== 2'b00 ||
            resp_data !== 32'h0 || resp_err !== 1'b0 || stack_push !== 32'h0 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: rw=%0d busy=%b count=%0d rv=%b rd=%h re=%b push=%h rdy=%b",
                     stack_rw, busy, count, resp_valid, resp_data, resp_err, stack_push, req_ready);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        check_init("reset");
    endtask

    task automatic test_push_pop();
        logic [31:0] words [3] = '{32'hA, 32'hB, 32'hC};
        logic [1:0] rv, rw_i; logic [31:0] rd; logic re; int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(0, 1'b0, words[i], rv, rd, re, rw_i, lat);
            vectors++;
            if (rv !== 2'b01 || re !== 1'b0 || lat != 1 || rw_i !== 2'd0 || count !== 2'(i + 1)) begin
                miscompares++;
                $display("FAIL push%0d: rv=%b err=%b lat=%0d rw=%0d count=%0d, want 01 0 1 0 %0d",
                         i, rv, re, lat, rw_i, count, i + 1);
            end
        end
        vectors++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flag: full=%b empty=%b, want 1 0", full, empty);
        end
        for (int i = 0; i < 3; i++) begin
            do_op(0, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
            vectors++;
            if (rv !== 2'b01 || re !== 1'b0 || lat != 2 || rw_i !== 2'd1 ||
                rd !== words[2-i] || count !== 2'(2 - i)) begin
                miscompares++;
                $display("FAIL pop%0d: rv=%b err=%b lat=%0d rw=%0d data=%h count=%0d, want 01 0 2 1 %h %0d",
                         i, rv, re, lat, rw_i, rd, count, words[2-i], 2 - i);
            end
        end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_flag: empty=%b full=%b, want 1 0", empty, full);
        end
    endtask

    task automatic test_errors();
        logic [1:0] rv, rw_i; logic [31:0] rd; logic re; int lat;
        for (int i = 1; i <= 3; i++) do_op(0, 1'b0, 32'(i), rv, rd, re, rw_i, lat);
        do_op(1, 1'b0, 32'hD, rv, rd, re, rw_i, lat);
        vectors++;
        if (rv !== 2'b10 || re !== 1'b1 || lat != 1 || rw_i !== 2'd2 || count !== 2'd3) begin
            miscompares++;
            $display("FAIL push_full: rv=%b err=%b lat=%0d rw=%0d count=%0d, want 10 1 1 2 3",
                     rv, re, lat, rw_i, count);
        end
        for (int i = 3; i >= 1; i--) begin
            do_op(0, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
            vectors++;
            if (rd !== 32'(i) || re !== 1'b0) begin
                miscompares++;
                $display("FAIL drain%0d: data=%h err=%b, want %h 0", i, rd, re, 32'(i));
            end
        end
        do_op(1, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
        vectors++;
        if (rv !== 2'b10 || re !== 1'b1 || lat != 1 || rw_i !== 2'd2 || count !== 2'd0 || rd !== 32'h1) begin
            miscompares++;
            $display("FAIL pop_empty: rv=%b err=%b lat=%0d rw=%0d count=%0d data=%h, want 10 1 1 2 0 1",
                     rv, re, lat, rw_i, count, rd);
        end
        tick();
        vectors++;
        if (resp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL resp_pulse: resp_valid=%b a cycle later, want 00", resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_g [3] = '{2'b01, 2'b10, 2'b01};
        logic [31:0] exp_w [3] = '{32'h10, 32'h20, 32'h11};
        logic [1:0] rv, rw_i; logic [31:0] rd; logic re; int lat; int wait_n;
        req_op = 2'b00;
        req_data = {32'h20, 32'h10};
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            wait_n = 0;
            while (req_ready == 2'b00 && wait_n < 20) begin
                tick();
                wait_n++;
            end
            vectors++;
            if (req_ready !== exp_g[k]) begin
                miscompares++;
                $display("FAIL rr_grant%0d: req_ready=%b, want %b", k, req_ready, exp_g[k]);
            end
            tick();
            vectors++;
            if (stack_rw !== 2'd0 || stack_push !== exp_w[k]) begin
                miscompares++;
                $display("FAIL rr_word%0d: rw=%0d push=%h, want 0 %h", k, stack_rw, stack_push, exp_w[k]);
            end
            if (k == 2) req_valid = 2'b00;
            else if (exp_g[k] == 2'b01) req_data[31:0] = 32'h11;
            else req_data[63:32] = 32'h21;
        end
        tick();
        tick();
        vectors++;
        if (count !== 2'd3) begin
            miscompares++;
            $display("FAIL rr_count: count=%0d, want 3", count);
        end
        for (int k = 2; k >= 0; k--) begin
            do_op(0, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
            vectors++;
            if (rd !== exp_w[k]) begin
                miscompares++;
                $display("FAIL rr_pop%0d: data=%h, want %h", k, rd, exp_w[k]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [1:0] rv, rw_i; logic [31:0] rd; logic re; int lat; int wait_n;
        do_op(0, 1'b0, 32'h77, rv, rd, re, rw_i, lat);
        req_op[0] = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        wait_n = 0;
        while (!req_ready[0] && wait_n < 20) begin
            tick();
            wait_n++;
        end
        tick();
        req_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (resp_valid !== 2'b00 || stack_rw !== 2'd2 || busy !== 1'b1 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL midop_reset: rv=%b rw=%0d busy=%b count=%0d, want 00 2 1 0",
                     resp_valid, stack_rw, busy, count);
        end
        tick();
        rst = 1'b0;
        check_init("midop");
        do_op(1, 1'b0, 32'h55, rv, rd, re, rw_i, lat);
        do_op(1, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
        vectors++;
        if (rv !== 2'b10 || rd !== 32'h55 || re !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_pop: rv=%b data=%h err=%b, want 10 55 0", rv, rd, re);
        end
    endtask

    task automatic test_data_hold();
        logic [1:0] rv, rw_i; logic [31:0] rd; logic re; int lat;
        do_op(1, 1'b0, 32'h99, rv, rd, re, rw_i, lat);
        force_val = 32'h1234;
        force_en = 1'b1;
        do_op(0, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
        force_en = 1'b0;
        vectors++;
        if (rv !== 2'b01 || rd !== 32'h1234) begin
            miscompares++;
            $display("FAIL pop_capture: rv=%b data=%h, want 01 1234", rv, rd);
        end
        do_op(1, 1'b0, 32'h42, rv, rd, re, rw_i, lat);
        vectors++;
        if (rv !== 2'b10 || rd !== 32'h1234 || re !== 1'b0) begin
            miscompares++;
            $display("FAIL data_hold: rv=%b data=%h err=%b, want 10 1234 0", rv, rd, re);
        end
        do_op(0, 1'b1, 32'h0, rv, rd, re, rw_i, lat);
        vectors++;
        if (rd !== 32'h42 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL hold_pop: data=%h count=%0d, want 42 0", rd, count);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        test_data_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Shares the single recursion stack between NUM_REQ requesters, such as the recursive datapath and a debug/unwind unit. It sequences every access onto the stack's 2-bit R_W command and tracks occupancy so the stack never over- or under-flows. It delivers pop data and acknowledgements back to the winning requester. It also re-synchronises the stack pointer after reset, because the stack itself has no reset.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
DATA_W, 32, stack word width
DEPTH, 3, usable stack entries (stack capacity)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_op  in  NUM_REQ  per-requester op: 0 push, 1 pop
req_data  in  NUM_REQ*DATA_W  push words, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant; combinational, high only in IDLE
resp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester
resp_data  out  DATA_W  popped word, valid with resp_valid on a pop
resp_err  out  1  qualifies resp_valid: push when full, or pop when empty
stack_rw  out  2  to stack R_W: 0 push, 1 pop, 2 nop
stack_push  out  DATA_W  to stack PUSH
stack_pop  in  DATA_W  from stack POP
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count==DEPTH
empty  out  1  count==0
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (async): state=INIT, init_cnt=0, count=0, stack_rw=2, stack_push=0, resp_valid=0, resp_data=0, resp_err=0, rr_ptr=0.
- All outputs except req_ready are registered.
- INIT: drive stack_rw=1 for DEPTH consecutive cycles, then move to IDLE.
  - These pops return the stack pointer to its base. Pops at base are ignored by the stack.
  - Pop data is discarded. No req_ready is given.
- IDLE: round-robin arbitration over req_valid, starting the search at rr_ptr.
  - Winner w gets req_ready[w]=1. This is the accept edge E0.
  - At E0: latch w, latch the op, set rr_ptr=(w+1)%NUM_REQ, go to ISSUE.
  - Legal push: stack_rw<=0, stack_push<=req_data[w].
  - Legal pop: stack_rw<=1.
  - Illegal op (push && full, or pop && empty): stack_rw<=2, err flag set.
- ISSUE (one cycle; the stack acts at edge E1). At E1: stack_rw<=2, then:
  - Push ok: count+1, resp_valid[w]=1 (err 0), go to IDLE.
  - Pop ok: count-1, go to POP_WAIT.
  - Error: resp_valid[w]=1, resp_err=1, count unchanged, go to IDLE.
- POP_WAIT (one cycle): at E2, resp_data<=stack_pop, resp_valid[w]=1, resp_err=0, go to IDLE.
- Latency from the accept edge:
  - Push or error: resp_valid is high in the cycle after E1.
  - Pop: resp_valid is high in the cycle after E2.
  - Maximum throughput is one push per 2 cycles and one pop per 3 cycles.
- resp_valid is always a single-cycle pulse. resp_data holds its last value between pops.
- Requests arriving while busy are held off (req_ready=0). Requesters must keep req_valid, req_op and req_data stable until granted.
- Simultaneous requests: exactly one grant per IDLE visit. A requester waits at most NUM_REQ-1 grants.
- count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-operation aborts the transaction with no resp_valid and re-enters INIT. The stack contents are lost; INIT resynchronises the pointer.

Decomposition:
- Package stack_arb_pkg:
  - Constants RW_PUSH=2'd0, RW_POP=2'd1, RW_NOP=2'd2, OP_PUSH=1'b0, OP_POP=1'b1.
  - State enum {INIT, IDLE, ISSUE, POP_WAIT}.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant and binary index.
  - Purely combinational; the parent owns rr_ptr.

Test Plan:
- Reset, then idle: stack_rw=1 for exactly 3 cycles, then 2. busy falls after the 3rd cycle, count=0, empty=1.
- Req0 pushes 0xA, 0xB, 0xC, then pops three times. Each push acks with err=0. Pops return 0xC, 0xB, 0xA, each with resp_valid[0] on the cycle after E2. count goes 3 -> 0.
- With full, req1 pushes 0xD: resp_valid[1] with resp_err=1, stack_rw stays 2, count stays 3. With empty, a pop gives resp_err=1.
- Both requesters hold valid pushes continuously: grants alternate 0, 1, 0, … and the stack receives the words interleaved. Stop pushing once count=3.
- Assert rst during POP_WAIT: no resp_valid appears. INIT re-runs with 3 pops. A subsequent push/pop of 0x55 returns 0x55.
- Pop with stack_pop driven to 0x1234 at E2: resp_data=0x1234, and it holds that value through the next push ack.
